// File: rtl/systolic_feeder.sv
// Skews flat K-slices onto an output-stationary PE array and sequences clear/feed/drain.
// Define SYSTOLIC_FEEDER_PERF_EN to add stall_cnt_o, a saturating count of FEED bubbles.
module systolic_feeder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ARRAY_HEIGHT = 4,
  parameter int ARRAY_WIDTH  = 4,
  parameter int K_MAX        = 16,
  parameter int PE_LAT       = 1,
  parameter int CNT_W        = $clog2(K_MAX + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     start_i,
  input  logic [CNT_W-1:0]                         k_len_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  input  logic                                     in_vld_i,
  output logic                                     in_rdy_o,
  input  logic [ARRAY_HEIGHT-1:0][DATA_WIDTH-1:0]  in_active_i,
  input  logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0]   in_weight_i,
  output logic                                     ctrl_start_o,
  output logic [ARRAY_HEIGHT-1:0][DATA_WIDTH-1:0]  active_o,
  output logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0]   weight_o,
  output logic                                     result_vld_o
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [15:0]                              stall_cnt_o
`endif
);

  // The last slice needs H+W-2 hops to reach the far corner PE, plus PE_LAT to land.
  localparam int DRAIN_CYC = ARRAY_HEIGHT + ARRAY_WIDTH - 2 + PE_LAT;
  localparam int DRAIN_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0]   K_CAP      = CNT_W'(K_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   k_q;
  logic [CNT_W-1:0]   acc_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic               result_vld_q;
  logic               accept;

  logic [ARRAY_HEIGHT-1:0][DATA_WIDTH-1:0] act_in;
  logic [ARRAY_WIDTH-1:0][DATA_WIDTH-1:0]  wgt_in;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = (k_q == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        if (in_vld_i) begin
          accept = 1'b1;
          if (acc_cnt_q + 1'b1 == k_q) state_d = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      acc_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      result_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start_i) begin
        k_q          <= (k_len_i > K_CAP) ? K_CAP : k_len_i;
        result_vld_q <= 1'b0;
      end
      if (state_q == S_CLEAR) begin
        acc_cnt_q <= '0;
      end else if (accept) begin
        acc_cnt_q <= acc_cnt_q + 1'b1;
      end
      if (state_q == S_DRAIN) begin
        drain_cnt_q <= drain_cnt_q + 1'b1;
      end else begin
        drain_cnt_q <= '0;
      end
      if (state_d == S_DONE) result_vld_q <= 1'b1;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign in_rdy_o     = (state_q == S_FEED);
  assign ctrl_start_o = (state_q == S_CLEAR);
  assign result_vld_o = result_vld_q;

  // Anything other than an accepted slice enters the skew lines as zero, so a
  // bubble or drain cycle contributes nothing to the accumulators.
  assign act_in = accept ? in_active_i : '0;
  assign wgt_in = accept ? in_weight_i : '0;

  for (genvar i = 0; i < ARRAY_HEIGHT; i++) begin : g_act
    logic [DATA_WIDTH-1:0] sr [0:i];
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int s = 0; s <= i; s++) sr[s] <= '0;
      end else begin
        sr[0] <= act_in[i];
        for (int s = 1; s <= i; s++) sr[s] <= sr[s-1];
      end
    end
    assign active_o[i] = sr[i];
  end

  for (genvar j = 0; j < ARRAY_WIDTH; j++) begin : g_wgt
    logic [DATA_WIDTH-1:0] sr [0:j];
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int s = 0; s <= j; s++) sr[s] <= '0;
      end else begin
        sr[0] <= wgt_in[j];
        for (int s = 1; s <= j; s++) sr[s] <= sr[s-1];
      end
    end
    assign weight_o[j] = sr[j];
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (state_q == S_CLEAR) begin
      stall_cnt_q <= '0;
    end else if (state_q == S_FEED && !in_vld_i && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
